// File: rtl/stamp_counter_mpps.sv
// Free-running DDS-clocked timestamp counter with selectable PPS source,
// loss-of-PPS watchdog, rate holdover and PPS timestamp capture.
module stamp_counter_mpps #(
    parameter int                   TIMESTAMP_WIDTH = 64,
    parameter int                   FRAC_BITS       = 5,
    parameter int                   DDS_WIDTH       = 32,
    parameter int                   NUM_PPS         = 2,
    parameter bit                   PPS_EDGE        = 1'b0,
    parameter logic [31:0]          PPS_TIMEOUT     = 32'h1312D000,
    parameter logic [DDS_WIDTH-1:0] DDS_DEFAULT     = '0,
    localparam int                  TW              = TIMESTAMP_WIDTH - FRAC_BITS,
    localparam int                  SEL_WIDTH       = (NUM_PPS > 1) ? $clog2(NUM_PPS) : 1
) (
    input  logic                       axi_aclk,
    input  logic                       axi_reset,
    input  logic [NUM_PPS-1:0]         pps_rx,
    input  logic [SEL_WIDTH-1:0]       pps_sel,
    input  logic [1:0]                 restart_time,
    input  logic [TIMESTAMP_WIDTH-1:0] ntp_timestamp,
    input  logic                       adjust_valid,
    input  logic [TW-1:0]              adjust_offset,
    input  logic [DDS_WIDTH-1:0]       dds_rate,
    output logic [TIMESTAMP_WIDTH-1:0] stamp_counter,
    output logic                       pps_valid,
    output logic                       gps_connected,
    output logic [TIMESTAMP_WIDTH-1:0] pps_stamp,
    output logic                       pps_stamp_valid,
    output logic [31:0]                pps_count
);

    logic [NUM_PPS-1:0]   r_d1, r_d2, r_d3;
    logic [NUM_PPS-1:0]   w_ev;
    logic                 w_pps_valid;
    logic [31:0]          r_watchdog;
    logic                 r_gps;
    logic [DDS_WIDTH-1:0] r_held_rate;
    logic [DDS_WIDTH-1:0] w_rate_used;
    logic [DDS_WIDTH-1:0] r_acc;
    logic [DDS_WIDTH:0]   w_sum;
    logic                 w_carry;
    logic [TW-1:0]        r_ticks;
    logic [TW-1:0]        w_step;
    logic [TIMESTAMP_WIDTH-1:0] r_pps_stamp;
    logic                 r_pps_stamp_valid;
    logic [31:0]          r_pps_count;
    logic                 w_unused;

    assign w_unused = ^ntp_timestamp[FRAC_BITS-1:0];

    // Each channel is synchronised on its own so a source switch cannot fake an edge.
    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            r_d1 <= '0;
            r_d2 <= '0;
            r_d3 <= '0;
        end else begin
            r_d1 <= pps_rx;
            r_d2 <= r_d1;
            r_d3 <= r_d2;
        end
    end

    assign w_ev = PPS_EDGE ? (r_d2 & ~r_d3) : (~r_d2 & r_d3);

    always_comb begin
        w_pps_valid = 1'b0;
        for (int i = 0; i < NUM_PPS; i++) begin
            if (pps_sel == SEL_WIDTH'(i)) w_pps_valid = w_ev[i];
        end
    end

    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            r_watchdog  <= PPS_TIMEOUT;
            r_gps       <= 1'b0;
            r_held_rate <= DDS_DEFAULT;
        end else begin
            if (w_pps_valid) begin
                r_watchdog <= PPS_TIMEOUT;
                r_gps      <= 1'b1;
            end else if (r_watchdog != 32'd0) begin
                r_watchdog <= r_watchdog - 32'd1;
            end else begin
                r_gps <= 1'b0;
            end
            if (r_gps) r_held_rate <= dds_rate;
        end
    end

    assign w_rate_used = r_gps ? dds_rate : r_held_rate;
    assign w_sum       = {1'b0, r_acc} + {1'b0, w_rate_used};
    assign w_carry     = w_sum[DDS_WIDTH];
    assign w_step      = adjust_valid ? adjust_offset : '0;

    // Load wins over clear, both win over adjust; the accumulator freezes on load/clear.
    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            r_ticks <= '0;
            r_acc   <= '0;
        end else if (restart_time[0]) begin
            r_ticks <= ntp_timestamp[TIMESTAMP_WIDTH-1:FRAC_BITS];
        end else if (restart_time[1]) begin
            r_ticks <= '0;
        end else begin
            r_ticks <= r_ticks + w_step + {{(TW-1){1'b0}}, w_carry};
            r_acc   <= w_sum[DDS_WIDTH-1:0];
        end
    end

    assign stamp_counter = {r_ticks, {FRAC_BITS{1'b0}}};

    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            r_pps_stamp       <= '0;
            r_pps_stamp_valid <= 1'b0;
            r_pps_count       <= '0;
        end else begin
            r_pps_stamp_valid <= w_pps_valid;
            if (w_pps_valid) begin
                r_pps_stamp <= stamp_counter;
                r_pps_count <= r_pps_count + 32'd1;
            end
        end
    end

    assign pps_valid       = w_pps_valid;
    assign gps_connected   = r_gps;
    assign pps_stamp       = r_pps_stamp;
    assign pps_stamp_valid = r_pps_stamp_valid;
    assign pps_count       = r_pps_count;

endmodule

// File: tb/tb_stamp_counter_mpps.sv
// Bench for stamp_counter_mpps: per-feature tasks, PPS captures checked through a scoreboard queue.
module tb_stamp_counter_mpps;
    localparam int TW = 59;

    logic          axi_aclk      = 1'b0;
    logic          axi_reset     = 1'b1;
    logic [1:0]    pps_rx        = 2'b11;
    logic [0:0]    pps_sel       = 1'b0;
    logic [1:0]    restart_time  = 2'b00;
    logic [63:0]   ntp_timestamp = '0;
    logic          adjust_valid  = 1'b0;
    logic [TW-1:0] adjust_offset = '0;
    logic [31:0]   dds_rate      = '0;
    logic [63:0]   stamp_counter;
    logic          pps_valid;
    logic          gps_connected;
    logic [63:0]   pps_stamp;
    logic          pps_stamp_valid;
    logic [31:0]   pps_count;

    int checks = 0;
    int errors = 0;
    logic [63:0] sb_q[$];

    stamp_counter_mpps #(
        .TIMESTAMP_WIDTH(64),
        .FRAC_BITS      (5),
        .DDS_WIDTH      (32),
        .NUM_PPS        (2),
        .PPS_EDGE       (1'b0),
        .PPS_TIMEOUT    (32'd16),
        .DDS_DEFAULT    (32'h8000_0000)
    ) dut (
        .axi_aclk       (axi_aclk),
        .axi_reset      (axi_reset),
        .pps_rx         (pps_rx),
        .pps_sel        (pps_sel),
        .restart_time   (restart_time),
        .ntp_timestamp  (ntp_timestamp),
        .adjust_valid   (adjust_valid),
        .adjust_offset  (adjust_offset),
        .dds_rate       (dds_rate),
        .stamp_counter  (stamp_counter),
        .pps_valid      (pps_valid),
        .gps_connected  (gps_connected),
        .pps_stamp      (pps_stamp),
        .pps_stamp_valid(pps_stamp_valid),
        .pps_count      (pps_count)
    );

    always #5 axi_aclk = ~axi_aclk;

    task automatic step(input int n);
        repeat (n) @(posedge axi_aclk);
        #1;
    endtask

    task automatic do_reset();
        axi_reset    = 1'b1;
        restart_time = 2'b00;
        adjust_valid = 1'b0;
        step(2);
        axi_reset = 1'b0;
    endtask

    // Falling edge on channel ch, with a load timed so the load lands in the pps_valid cycle.
    task automatic pps_event(input int ch, input logic [63:0] val, input logic adj);
        logic [63:0] exp;
        step(4);
        pps_rx[ch] = 1'b0;
        step(1);
        checks++;
        if (pps_valid !== 1'b0) begin
            errors++;
            $display("FAIL pps_early: got %b expected 0", pps_valid);
        end
        exp = {val[63:5], 5'b0};
        sb_q.push_back(exp);
        restart_time  = 2'b01;
        ntp_timestamp = val;
        step(1);
        restart_time = 2'b00;
        checks++;
        if (pps_valid !== 1'b1) begin
            errors++;
            $display("FAIL pps_valid_timing: got %b expected 1", pps_valid);
        end
        checks++;
        if (stamp_counter !== exp) begin
            errors++;
            $display("FAIL stamp_at_pps: got %h expected %h", stamp_counter, exp);
        end
        if (adj) begin
            adjust_valid  = 1'b1;
            adjust_offset = 59'h10;
        end
        step(1);
        adjust_valid = 1'b0;
        pps_rx[ch]   = 1'b1;
        checks++;
        if (pps_stamp_valid !== 1'b1) begin
            errors++;
            $display("FAIL pps_stamp_valid: got %b expected 1", pps_stamp_valid);
        end
        exp = sb_q.pop_front();
        checks++;
        if (pps_stamp !== exp) begin
            errors++;
            $display("FAIL pps_stamp: got %h expected %h", pps_stamp, exp);
        end
        checks++;
        if (gps_connected !== 1'b1) begin
            errors++;
            $display("FAIL gps_after_pps: got %b expected 1", gps_connected);
        end
        step(1);
        checks++;
        if (pps_stamp_valid !== 1'b0) begin
            errors++;
            $display("FAIL pps_stamp_valid_pulse: got %b expected 0", pps_stamp_valid);
        end
    endtask

    task automatic test_reset();
        axi_reset = 1'b1;
        step(2);
        checks++;
        if (stamp_counter !== 64'h0) begin errors++; $display("FAIL rst_stamp: got %h expected 0", stamp_counter); end
        checks++;
        if (pps_stamp !== 64'h0) begin errors++; $display("FAIL rst_pps_stamp: got %h expected 0", pps_stamp); end
        checks++;
        if (pps_count !== 32'h0) begin errors++; $display("FAIL rst_pps_count: got %h expected 0", pps_count); end
        checks++;
        if ({gps_connected, pps_valid, pps_stamp_valid} !== 3'b000) begin
            errors++;
            $display("FAIL rst_flags: got %b expected 000", {gps_connected, pps_valid, pps_stamp_valid});
        end
        axi_reset = 1'b0;
    endtask

    task automatic test_rate();
        do_reset();
        dds_rate = 32'h8000_0000;
        step(10);
        checks++;
        if (stamp_counter !== 64'hA0) begin errors++; $display("FAIL rate_10cyc: got %h expected a0", stamp_counter); end
    endtask

    task automatic test_load_priority();
        do_reset();
        restart_time  = 2'b11;
        ntp_timestamp = 64'h1000;
        adjust_valid  = 1'b1;
        adjust_offset = 59'h55;
        step(1);
        checks++;
        if (stamp_counter !== 64'h1000) begin errors++; $display("FAIL load_wins: got %h expected 1000", stamp_counter); end
        restart_time = 2'b10;
        step(1);
        checks++;
        if (stamp_counter !== 64'h0) begin errors++; $display("FAIL clear_wins: got %h expected 0", stamp_counter); end
        restart_time  = 2'b01;
        adjust_valid  = 1'b0;
        ntp_timestamp = 64'h123F;
        step(1);
        restart_time = 2'b00;
        checks++;
        if (stamp_counter !== 64'h1220) begin errors++; $display("FAIL load_frac_ignored: got %h expected 1220", stamp_counter); end
        step(1);
        checks++;
        if (stamp_counter !== 64'h1220) begin errors++; $display("FAIL acc_held_1: got %h expected 1220", stamp_counter); end
        step(1);
        checks++;
        if (stamp_counter !== 64'h1240) begin errors++; $display("FAIL acc_held_2: got %h expected 1240", stamp_counter); end
    endtask

    task automatic test_adjust();
        do_reset();
        restart_time  = 2'b01;
        ntp_timestamp = 64'h60;
        step(1);
        restart_time = 2'b00;
        step(1);
        checks++;
        if (stamp_counter !== 64'h60) begin errors++; $display("FAIL adj_pre: got %h expected 60", stamp_counter); end
        adjust_valid  = 1'b1;
        adjust_offset = ~59'd1;
        step(1);
        adjust_valid = 1'b0;
        checks++;
        if (stamp_counter !== 64'h40) begin errors++; $display("FAIL adj_neg_carry: got %h expected 40", stamp_counter); end
        restart_time  = 2'b01;
        ntp_timestamp = 64'hFFFF_FFFF_FFFF_FFFF;
        step(1);
        restart_time = 2'b00;
        step(1);
        checks++;
        if (stamp_counter !== 64'hFFFF_FFFF_FFFF_FFE0) begin errors++; $display("FAIL load_ones: got %h expected ffffffffffffffe0", stamp_counter); end
        step(1);
        checks++;
        if (stamp_counter !== 64'h0) begin errors++; $display("FAIL tick_wrap: got %h expected 0", stamp_counter); end
        adjust_valid  = 1'b1;
        adjust_offset = 59'd7;
        step(1);
        checks++;
        if (stamp_counter !== 64'hE0) begin errors++; $display("FAIL adj_pos_nocarry: got %h expected e0", stamp_counter); end
        adjust_offset = ~59'd7;
        step(1);
        adjust_valid = 1'b0;
        checks++;
        if (stamp_counter !== 64'h0) begin errors++; $display("FAIL adj_neg8_carry: got %h expected 0", stamp_counter); end
    endtask

    task automatic test_pps();
        logic seen;
        do_reset();
        pps_sel = 1'b1;
        pps_event(1, 64'h2A0, 1'b1);
        checks++;
        if (pps_count !== 32'd1) begin errors++; $display("FAIL pps_count_1: got %0d expected 1", pps_count); end
        seen = 1'b0;
        pps_rx[0] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            if (pps_valid !== 1'b0) seen = 1'b1;
        end
        pps_sel = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1);
            if (pps_valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL unselected_or_switch_event: got %b expected 0", seen); end
        checks++;
        if (pps_count !== 32'd1) begin errors++; $display("FAIL pps_count_hold: got %0d expected 1", pps_count); end
        pps_rx[0] = 1'b1;
        step(4);
    endtask

    task automatic test_timeout();
        do_reset();
        pps_sel = 1'b0;
        step(30);
        checks++;
        if (gps_connected !== 1'b0) begin errors++; $display("FAIL gps_no_pps: got %b expected 0", gps_connected); end
        pps_event(0, 64'h7700, 1'b0);
        step(15);
        checks++;
        if (gps_connected !== 1'b1) begin errors++; $display("FAIL gps_before_drop: got %b expected 1", gps_connected); end
        step(1);
        checks++;
        if (gps_connected !== 1'b0) begin errors++; $display("FAIL gps_drop: got %b expected 0", gps_connected); end
        step(20);
        checks++;
        if (gps_connected !== 1'b0) begin errors++; $display("FAIL gps_stays_low: got %b expected 0", gps_connected); end
    endtask

    task automatic test_holdover();
        logic [63:0] t0;
        logic        got;
        do_reset();
        pps_sel  = 1'b0;
        dds_rate = 32'h4000_0000;
        pps_event(0, 64'h0, 1'b0);
        t0 = stamp_counter;
        step(16);
        checks++;
        if (stamp_counter - t0 !== 64'h80) begin errors++; $display("FAIL connected_rate: got %h expected 80", stamp_counter - t0); end
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            if (gps_connected === 1'b0) got = 1'b1;
            else step(1);
        end
        checks++;
        if (got !== 1'b1) begin errors++; $display("FAIL loss_timeout: got %b expected 1", got); end
        dds_rate = 32'h8000_0000;
        t0 = stamp_counter;
        step(16);
        checks++;
        if (stamp_counter - t0 !== 64'h80) begin errors++; $display("FAIL holdover_rate: got %h expected 80", stamp_counter - t0); end
        pps_event(0, 64'h1000, 1'b0);
        t0 = stamp_counter;
        step(16);
        checks++;
        if (stamp_counter - t0 !== 64'h100) begin errors++; $display("FAIL reconnect_rate: got %h expected 100", stamp_counter - t0); end
        checks++;
        if (pps_count !== 32'd2) begin errors++; $display("FAIL pps_count_2: got %0d expected 2", pps_count); end
    endtask

    task automatic test_mid_reset();
        axi_reset = 1'b1;
        step(1);
        checks++;
        if ({stamp_counter, pps_stamp} !== 128'h0) begin
            errors++;
            $display("FAIL midrst_stamps: got %h/%h expected 0/0", stamp_counter, pps_stamp);
        end
        checks++;
        if ({pps_count, gps_connected} !== 33'h0) begin
            errors++;
            $display("FAIL midrst_count_gps: got %0d/%b expected 0/0", pps_count, gps_connected);
        end
        axi_reset = 1'b0;
        step(1);
        checks++;
        if (stamp_counter !== 64'h0) begin errors++; $display("FAIL midrst_acc_1: got %h expected 0", stamp_counter); end
        step(1);
        checks++;
        if (stamp_counter !== 64'h20) begin errors++; $display("FAIL midrst_acc_2: got %h expected 20", stamp_counter); end
    endtask

    initial begin
        test_reset();
        test_rate();
        test_load_priority();
        test_adjust();
        test_pps();
        test_timeout();
        test_holdover();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

endmodule
